// File: rtl/ooo_pkg.sv
// Shared sizes and types for the rename stage and its free list: physical
// tags, architectural indices, FU classes and the registered rename bundle.
package ooo_pkg;
    localparam int XLEN      = 32;
    localparam int ARCH_REGS = 16;
    localparam int AREG_W    = $clog2(ARCH_REGS);
    localparam int PREG_W    = 5;
    localparam int PREGS     = 2 ** PREG_W;
    localparam int FL_DEPTH  = PREGS - ARCH_REGS;
    localparam int FL_PTR_W  = $clog2(FL_DEPTH);
    localparam int FL_CNT_W  = $clog2(FL_DEPTH + 1);

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [AREG_W-1:0] areg_t;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_LSU = 2'd1,
        FU_MUL = 2'd2
    } fu_type_e;

    typedef struct packed {
        logic            alloc;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        preg_t           prs1;
        preg_t           prs2;
        preg_t           prd;
        preg_t           old_prd;
        logic            prs1_vld;
        logic            prs2_vld;
        logic [2:0]      fu;
    } rename_out_t;
endpackage

// File: rtl/free_list.sv
// Physical-tag free list: circular FIFO preloaded with tags ARCH_REGS..PREGS-1, head visible
// combinationally; FREELIST_BYPASS_EN lets an empty list hand a same-cycle push straight to the popper.
module free_list
    import ooo_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                push_i,
    input  preg_t               push_tag_i,
    input  logic                pop_i,
    output preg_t               head_o,
    output logic [FL_CNT_W-1:0] count_o,
    output logic                bypass_o
);
    preg_t               mem [FL_DEPTH];
    logic [FL_PTR_W-1:0] head_q;
    logic [FL_PTR_W-1:0] tail_q;
    logic [FL_CNT_W-1:0] count_q;
    logic                push_ok;
    logic                empty;
    logic                full;
    logic                do_push;
    logic                do_pop;

    // Tag 0 is the hardwired-zero register and must never circulate.
    assign push_ok = push_i & (push_tag_i != '0);
    assign empty   = (count_q == '0);
    assign full    = (count_q == FL_CNT_W'(FL_DEPTH));

`ifdef FREELIST_BYPASS_EN
    assign bypass_o = empty & push_ok;
`else
    assign bypass_o = 1'b0;
`endif

    assign head_o  = bypass_o ? push_tag_i : mem[head_q];
    assign do_pop  = pop_i & ~empty;
    assign do_push = push_ok & ~full & ~(bypass_o & pop_i);
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem[i] <= preg_t'(ARCH_REGS + i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= FL_CNT_W'(FL_DEPTH);
        end else begin
            if (do_push) begin
                mem[tail_q] <= push_tag_i;
                tail_q      <= tail_q + FL_PTR_W'(1);
            end
            if (do_pop) begin
                head_q <= head_q + FL_PTR_W'(1);
            end
            count_q <= count_q + FL_CNT_W'(do_push) - FL_CNT_W'(do_pop);
        end
    end

    push_when_full: assert property (@(posedge clk_i) disable iff (!reset_ni) !(push_ok && full));
endmodule

// File: rtl/rename_stage.sv
// Rename stage: RAT lookup, free-list allocation and busy tracking; outputs registered, 1-cycle latency.
// Ready is combinational from FU space and tag availability; optional FREELIST_BYPASS_EN via free_list.
module rename_stage
    import ooo_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            rename_valid_i,
    output logic            rename_ready_o,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] inst_i,
    input  areg_t           rs1_arch_i,
    input  areg_t           rs2_arch_i,
    input  areg_t           rd_arch_i,
    input  logic            rd_we_i,
    input  logic            alu_request_i,
    input  logic            lsu_request_i,
    input  logic            mul_request_i,
    input  logic            alu_free_i,
    input  logic            lsu_free_i,
    input  logic            mul_free_i,
    input  logic            cdb_en_i,
    input  preg_t           cdb_tag_i,
    input  logic            free_en_i,
    input  preg_t           free_tag_i,
    output logic            rs_allocate_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] inst_o,
    output preg_t           prs1_addr_o,
    output preg_t           prs2_addr_o,
    output preg_t           prd_addr_o,
    output logic            prs1_valid_o,
    output logic            prs2_valid_o,
    output logic            alu_request_o,
    output logic            lsu_request_o,
    output logic            mul_request_o,
    output preg_t           old_prd_o
);
    preg_t               rat [ARCH_REGS];
    logic [PREGS-1:0]    busy_q;
    preg_t               fl_head;
    logic [FL_CNT_W-1:0] fl_count;
    logic                fl_bypass;
    logic                need_tag;
    logic                fu_free;
    logic                fire;
    logic                alloc;
    preg_t               prs1;
    preg_t               prs2;
    rename_out_t         out_q;
    rename_out_t         out_d;

    function automatic logic src_ready(preg_t tag, logic [PREGS-1:0] busy, logic cdb_en, preg_t cdb_tag);
        return ~busy[tag] | (cdb_en & (cdb_tag == tag)) | (tag == '0);
    endfunction

    assign need_tag       = rd_we_i & (rd_arch_i != '0);
    assign fu_free        = (alu_request_i & alu_free_i) | (lsu_request_i & lsu_free_i)
                          | (mul_request_i & mul_free_i);
    assign rename_ready_o = fu_free & (~need_tag | (fl_count != '0) | fl_bypass);
    assign fire           = rename_valid_i & rename_ready_o;
    assign alloc          = fire & need_tag;

    // Sources read the mapping from before this cycle's rd write.
    assign prs1 = rat[rs1_arch_i];
    assign prs2 = rat[rs2_arch_i];

    free_list u_fl (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .push_i     (free_en_i),
        .push_tag_i (free_tag_i),
        .pop_i      (alloc),
        .head_o     (fl_head),
        .count_o    (fl_count),
        .bypass_o   (fl_bypass)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat[i] <= preg_t'(i);
            end
        end else if (alloc) begin
            rat[rd_arch_i] <= fl_head;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            busy_q <= '0;
        end else begin
            if (cdb_en_i) begin
                busy_q[cdb_tag_i] <= 1'b0;
            end
            if (alloc) begin
                busy_q[fl_head] <= 1'b1;
            end
        end
    end

    always_comb begin
        out_d       = out_q;
        out_d.alloc = fire;
        if (fire) begin
            out_d.pc          = pc_i;
            out_d.inst        = inst_i;
            out_d.prs1        = prs1;
            out_d.prs2        = prs2;
            out_d.prs1_vld    = src_ready(prs1, busy_q, cdb_en_i, cdb_tag_i);
            out_d.prs2_vld    = src_ready(prs2, busy_q, cdb_en_i, cdb_tag_i);
            out_d.prd         = need_tag ? fl_head : '0;
            out_d.old_prd     = need_tag ? rat[rd_arch_i] : '0;
            out_d.fu[FU_ALU]  = alu_request_i;
            out_d.fu[FU_LSU]  = lsu_request_i;
            out_d.fu[FU_MUL]  = mul_request_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign rs_allocate_o = out_q.alloc;
    assign pc_o          = out_q.pc;
    assign inst_o        = out_q.inst;
    assign prs1_addr_o   = out_q.prs1;
    assign prs2_addr_o   = out_q.prs2;
    assign prd_addr_o    = out_q.prd;
    assign old_prd_o     = out_q.old_prd;
    assign prs1_valid_o  = out_q.prs1_vld;
    assign prs2_valid_o  = out_q.prs2_vld;
    assign alu_request_o = out_q.fu[FU_ALU];
    assign lsu_request_o = out_q.fu[FU_LSU];
    assign mul_request_o = out_q.fu[FU_MUL];
endmodule

// File: tb/tb_rename_stage.sv
// Bench for rename_stage: directed steps plus random traffic against a queue/array
// reference model; honours FREELIST_BYPASS_EN when defined.
module tb_rename_stage;
    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        rename_valid_i;
    logic        rename_ready_o;
    logic [31:0] pc_i, inst_i;
    logic [3:0]  rs1_arch_i, rs2_arch_i, rd_arch_i;
    logic        rd_we_i;
    logic        alu_request_i, lsu_request_i, mul_request_i;
    logic        alu_free_i, lsu_free_i, mul_free_i;
    logic        cdb_en_i;
    logic [4:0]  cdb_tag_i;
    logic        free_en_i;
    logic [4:0]  free_tag_i;
    logic        rs_allocate_o;
    logic [31:0] pc_o, inst_o;
    logic [4:0]  prs1_addr_o, prs2_addr_o, prd_addr_o, old_prd_o;
    logic        prs1_valid_o, prs2_valid_o;
    logic        alu_request_o, lsu_request_o, mul_request_o;

    always #5 clk_i = ~clk_i;

    rename_stage dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .rename_valid_i(rename_valid_i), .rename_ready_o(rename_ready_o),
        .pc_i(pc_i), .inst_i(inst_i),
        .rs1_arch_i(rs1_arch_i), .rs2_arch_i(rs2_arch_i), .rd_arch_i(rd_arch_i), .rd_we_i(rd_we_i),
        .alu_request_i(alu_request_i), .lsu_request_i(lsu_request_i), .mul_request_i(mul_request_i),
        .alu_free_i(alu_free_i), .lsu_free_i(lsu_free_i), .mul_free_i(mul_free_i),
        .cdb_en_i(cdb_en_i), .cdb_tag_i(cdb_tag_i),
        .free_en_i(free_en_i), .free_tag_i(free_tag_i),
        .rs_allocate_o(rs_allocate_o), .pc_o(pc_o), .inst_o(inst_o),
        .prs1_addr_o(prs1_addr_o), .prs2_addr_o(prs2_addr_o), .prd_addr_o(prd_addr_o),
        .prs1_valid_o(prs1_valid_o), .prs2_valid_o(prs2_valid_o),
        .alu_request_o(alu_request_o), .lsu_request_o(lsu_request_o), .mul_request_o(mul_request_o),
        .old_prd_o(old_prd_o)
    );

`ifdef FREELIST_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int assertions = 0;
    int failures   = 0;

    // Reference model: mapping table, busy flags, free tags in order, retired tags awaiting release.
    int rat_m [16];
    bit busy_m [32];
    int fl_m [$];
    int pool_m [$];

    bit        e_alloc, e_v1, e_v2, e_alu, e_lsu, e_mul, exp_ready;
    bit [31:0] e_pc, e_inst;
    int        e_prs1, e_prs2, e_prd, e_old;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit src_ok(input int t);
        return !busy_m[t] || (cdb_en_i && (int'(cdb_tag_i) == t)) || (t == 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) rat_m[i] = i;
        for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
        fl_m.delete();
        for (int i = 16; i < 32; i++) fl_m.push_back(i);
        pool_m.delete();
        e_alloc = 0; e_v1 = 0; e_v2 = 0; e_alu = 0; e_lsu = 0; e_mul = 0;
        e_pc = 0; e_inst = 0; e_prs1 = 0; e_prs2 = 0; e_prd = 0; e_old = 0;
    endtask

    task automatic check_outs();
        chk("rs_allocate", rs_allocate_o, e_alloc);
        chk("pc", pc_o, e_pc);
        chk("inst", inst_o, e_inst);
        chk("prs1_addr", prs1_addr_o, e_prs1);
        chk("prs2_addr", prs2_addr_o, e_prs2);
        chk("prs1_valid", prs1_valid_o, e_v1);
        chk("prs2_valid", prs2_valid_o, e_v2);
        chk("prd_addr", prd_addr_o, e_prd);
        chk("old_prd", old_prd_o, e_old);
        chk("fu_type", {alu_request_o, lsu_request_o, mul_request_o}, {e_alu, e_lsu, e_mul});
        chk("fl_count", dut.u_fl.count_o, fl_m.size());
    endtask

    task automatic drive(input bit v, input int s1, input int s2, input int d, input bit we, input int fu);
        rename_valid_i = v;
        rs1_arch_i = 4'(s1); rs2_arch_i = 4'(s2); rd_arch_i = 4'(d); rd_we_i = we;
        alu_request_i = (fu == 0); lsu_request_i = (fu == 1); mul_request_i = (fu == 2);
        alu_free_i = 1; lsu_free_i = 1; mul_free_i = 1;
        cdb_en_i = 0; cdb_tag_i = 0; free_en_i = 0; free_tag_i = 0;
        pc_i = $urandom; inst_i = $urandom;
    endtask

    // Entered at posedge+1 with inputs applied; leaves at the next posedge+1.
    task automatic cycle();
        bit need, fu_ok, push_ok, byp, fire;
        int head;
        head    = 0;
        need    = rd_we_i && (rd_arch_i != 0);
        fu_ok   = (alu_request_i && alu_free_i) || (lsu_request_i && lsu_free_i) ||
                  (mul_request_i && mul_free_i);
        push_ok = free_en_i && (free_tag_i != 0);
        byp     = BYP && (fl_m.size() == 0) && push_ok;
        exp_ready = fu_ok && (!need || fl_m.size() != 0 || byp);
        fire    = rename_valid_i && exp_ready;
        #3;
        chk("rename_ready", rename_ready_o, exp_ready);
        if (!reset_ni) begin
            model_reset();
        end else begin
            e_alloc = fire;
            if (fire) begin
                e_pc = pc_i; e_inst = inst_i;
                e_prs1 = rat_m[rs1_arch_i]; e_prs2 = rat_m[rs2_arch_i];
                e_v1 = src_ok(e_prs1); e_v2 = src_ok(e_prs2);
                e_alu = alu_request_i; e_lsu = lsu_request_i; e_mul = mul_request_i;
                if (need) begin
                    head  = byp ? int'(free_tag_i) : fl_m[0];
                    e_prd = head;
                    e_old = rat_m[rd_arch_i];
                    pool_m.push_back(e_old);
                end else begin
                    e_prd = 0; e_old = 0;
                end
            end
            if (cdb_en_i) busy_m[cdb_tag_i] = 1'b0;
            if (fire && need) begin
                busy_m[head] = 1'b1;
                rat_m[rd_arch_i] = head;
                if (!byp) void'(fl_m.pop_front());
            end
            if (push_ok && !(byp && fire && need)) fl_m.push_back(int'(free_tag_i));
        end
        @(posedge clk_i); #1;
        check_outs();
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        reset_ni = 0;
        @(posedge clk_i); #1;
        reset_ni = 1;
        model_reset();
        check_outs();
    endtask

    task automatic rand_step();
        int bq[$];
        int sel;
        rename_valid_i = ($urandom_range(0, 9) < 8);
        rs1_arch_i = 4'($urandom_range(0, 15));
        rs2_arch_i = 4'($urandom_range(0, 15));
        rd_arch_i  = 4'($urandom_range(0, 15));
        rd_we_i    = ($urandom_range(0, 3) != 0);
        sel = $urandom_range(0, 2);
        alu_request_i = (sel == 0); lsu_request_i = (sel == 1); mul_request_i = (sel == 2);
        alu_free_i = ($urandom_range(0, 3) != 0);
        lsu_free_i = ($urandom_range(0, 3) != 0);
        mul_free_i = ($urandom_range(0, 3) != 0);
        pc_i = $urandom; inst_i = $urandom;
        for (int t = 1; t < 32; t++) if (busy_m[t]) bq.push_back(t);
        cdb_en_i  = (bq.size() != 0) && ($urandom_range(0, 1) == 1);
        cdb_tag_i = cdb_en_i ? 5'(bq[$urandom_range(0, bq.size() - 1)]) : 5'($urandom_range(0, 31));
        if (pool_m.size() != 0 && !busy_m[pool_m[0]] && fl_m.size() < 16 && $urandom_range(0, 2) == 0) begin
            free_en_i = 1; free_tag_i = 5'(pool_m.pop_front());
        end else begin
            free_en_i = 0; free_tag_i = 5'($urandom_range(0, 31));
        end
    endtask

    initial begin
        reset_ni = 0;
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk_i); #1;
        do_reset();

        // First rename, then a consumer of the new tag.
        drive(1, 2, 3, 5, 1, 0); cycle();
        chk("t1_prs1", prs1_addr_o, 2);
        chk("t1_prd", prd_addr_o, 16);
        chk("t1_old_prd", old_prd_o, 5);
        drive(1, 5, 0, 0, 0, 0); cycle();
        chk("t1_prs1_fwd", prs1_addr_o, 16);
        chk("t1_prs1_busy", prs1_valid_o, 0);

        // Completion broadcast in the same cycle as the read.
        drive(1, 5, 3, 0, 0, 1); cdb_en_i = 1; cdb_tag_i = 16; cycle();
        chk("t2_cdb_same_cycle", prs1_valid_o, 1);
        drive(1, 5, 3, 0, 0, 2); cycle();
        chk("t2_after_cdb", prs1_valid_o, 1);

        // Exhaust the free list, stall, then refill with tag 7.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 2, 1, 1, 0); cycle();
            chk("t3_prd", prd_addr_o, 16 + i);
            chk("t3_old_prd", old_prd_o, (i == 0) ? 1 : 15 + i);
        end
        drive(1, 1, 2, 1, 1, 0); cycle();
        chk("t3_stall", rs_allocate_o, 0);
        drive(1, 1, 2, 1, 1, 0); free_en_i = 1; free_tag_i = 7; cycle();
        chk("t3_refill_alloc", rs_allocate_o, BYP);
        drive(1, 1, 2, 1, 1, 0); cycle();
        chk("t3_refill_prd", prd_addr_o, 7);

        // rd=0 needs no tag; tag-0 release is ignored.
        do_reset();
        drive(1, 0, 4, 0, 1, 0); free_en_i = 1; free_tag_i = 0; cycle();
        chk("t4_prd_zero", prd_addr_o, 0);
        chk("t4_prs1_zero_valid", prs1_valid_o, 1);
        chk("t4_count", dut.u_fl.count_o, 16);

        // Requested FU full while another has room.
        drive(1, 1, 2, 3, 1, 2); mul_free_i = 0; cycle();
        chk("t5_no_alloc", rs_allocate_o, 0);
        chk("t5_count", dut.u_fl.count_o, 16);

        // Pop and push together at count 1.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(1, 0, 0, 1 + i, 1, 0); cycle();
        end
        drive(1, 0, 0, 2, 1, 1); free_en_i = 1; free_tag_i = 9; cycle();
        chk("t6_prd_last", prd_addr_o, 31);
        chk("t6_count", dut.u_fl.count_o, 1);
        drive(1, 0, 0, 3, 1, 0); cycle();
        chk("t6_prd_9", prd_addr_o, 9);

        // Random traffic with retirement and completion.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rand_step(); cycle();
        end

        // Reset while an allocation is in flight.
        drive(1, 1, 2, 3, 1, 0); cycle();
        rand_step(); rename_valid_i = 1; reset_ni = 0; cycle();
        reset_ni = 1;
        chk("rst_alloc", rs_allocate_o, 0);
        chk("rst_count", dut.u_fl.count_o, 16);
        drive(1, 5, 6, 7, 1, 0); cycle();
        chk("rst_rat_prs1", prs1_addr_o, 5);
        chk("rst_rat_old", old_prd_o, 7);
        chk("rst_prd", prd_addr_o, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- Register-rename stage directly upstream of the reservation station (`rs`).
- Maps architectural source/destination registers to physical tags via a register alias table (RAT).
- Allocates new destination tags from a free list and tracks tag readiness in a busy table, cleared by CDB broadcasts.
- Drives `rs` allocate fields (pc, inst, prs1/prs2/prd, source-valid bits, FU-type request) through one output register stage.

Parameters:
- ARCH_REGS, 16, number of architectural registers (RV32E); arch register 0 is hardwired zero.
- PREG_W, 5, physical tag width; PREGS = 2**PREG_W = 32 physical registers.
- FL_DEPTH, PREGS-ARCH_REGS (16), free-list capacity.

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  synchronous active-low reset
- rename_valid_i  in  1  decoded instruction present
- rename_ready_o  out  1  stage accepts instruction this cycle
- pc_i  in  32  instruction PC
- inst_i  in  32  instruction word
- rs1_arch_i  in  4  arch source 1
- rs2_arch_i  in  4  arch source 2
- rd_arch_i  in  4  arch destination
- rd_we_i  in  1  instruction writes rd
- alu_request_i / lsu_request_i / mul_request_i  in  1 each  FU type, one-hot
- alu_free_i / lsu_free_i / mul_free_i  in  1 each  RS space available, from `rs`
- cdb_en_i  in  1  CDB broadcast valid
- cdb_tag_i  in  PREG_W  completing physical tag
- free_en_i  in  1  commit returns a tag
- free_tag_i  in  PREG_W  tag returned to free list
- rs_allocate_o  out  1  allocate request to `rs`
- pc_o, inst_o  out  32 each  registered pc/inst
- prs1_addr_o, prs2_addr_o, prd_addr_o  out  PREG_W each  physical tags
- prs1_valid_o, prs2_valid_o  out  1 each  source operand ready
- alu_request_o / lsu_request_o / mul_request_o  out  1 each  registered FU type
- old_prd_o  out  PREG_W  previous mapping of rd, for the ROB

Behaviour:
- Clock and reset: one clock `clk_i`; reset `reset_ni` is synchronous and active-low.
- Reset state:
  - RAT[i]=i for all i.
  - Free list holds tags 16..31 in ascending order; count=16.
  - Busy table all clear.
  - All outputs 0.
- Fire condition: fire = rename_valid_i & rename_ready_o.
- Ready equation:
  - rename_ready_o = fu_free & (~need_tag | fl_count!=0).
  - need_tag = rd_we_i & (rd_arch_i!=0).
  - fu_free is the *_free_i bit selected by the one-hot request.
  - Purely combinational; depends on no other output.
- On fire, all outputs are registered next cycle with 1-cycle latency:
  - rs_allocate_o=1.
  - prsN_addr_o = RAT[rsN_arch_i], read before this cycle's RAT write.
  - prsN_valid_o = ~busy[tag] | (cdb_en_i & cdb_tag_i==tag) | (tag==0).
  - If need_tag: prd_addr_o = free-list head; pop the free list; RAT[rd]=head; busy[head]=1; old_prd_o = previous RAT[rd].
  - If ~need_tag: prd_addr_o=0, old_prd_o=0, no pop.
- No fire: rs_allocate_o=0 next cycle; data outputs hold their previous values.
- Same-instruction rd==rs1/rs2: sources read the old mapping.
- Busy clear: on cdb_en_i, busy[cdb_tag_i]=0. A set and clear of the same tag in one cycle cannot occur, because the allocated tag is never in flight.
- Tag 0: never busy and never allocated; free_en_i with tag 0 is ignored.
- Free list: circular FIFO of FL_DEPTH entries; head/tail pointers wrap modulo FL_DEPTH.
  - Push on free_en_i; pop on fire&need_tag.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Push when full is illegal; flag with a simulation assertion, state unchanged.
- Reset mid-operation: all state returns to reset values in the same edge; an in-flight rs_allocate_o drops to 0.

Optional Feature:
- FREELIST_BYPASS_EN
  - Defined: when fl_count==0 and free_en_i=1 (tag!=0), need_tag instructions are ready and take free_tag_i directly. The pushed tag does not enter the FIFO; count stays 0.
  - Undefined: no bypass; ready stays 0 until the cycle after the push.

Decomposition:
- Package `ooo_pkg`: PREG_W, ARCH_REGS, typedef preg_t (logic [PREG_W-1:0]), areg_t, fu_type_e (ALU/LSU/MUL), struct rename_out_t bundling the registered outputs.
- Sub-module `free_list`: FIFO with reset preload, push/pop, count, empty/full, optional bypass.
- RAT, busy table and output register stay in `rename_stage`.

Test Plan:
- Reset, then rename rs1=2, rs2=3, rd=5, ALU, all free -> next cycle rs_allocate_o=1, prs1=2, prs2=3, valids=1, prd=16, old_prd=5; then rs1=5 -> prs1=16, prs1_valid=0.
- Tag 16 busy, CDB tag 16 in the same cycle as renaming rs1=5 -> prs1_valid_o=1; subsequent renames also see valid=1.
- Issue 16 renames with rd=1 -> prd 16..31, each old_prd = previous prd; 17th rd write -> rename_ready_o=0. free_en_i tag 7 -> ready next cycle, prd=7 (same cycle with FREELIST_BYPASS_EN).
- rd=0 with rd_we_i=1 -> prd_addr_o=0, free-list count unchanged; rs1=0 -> prs1_valid=1.
- mul_request_i with mul_free_i=0, alu_free_i=1 -> rename_ready_o=0, rs_allocate_o stays 0, no state change.
- Simultaneous pop and free_en_i tag 9 at count=1 -> count stays 1, next allocation returns 9; reset asserted mid-stream -> RAT identity, count=16, rs_allocate_o=0.
